// File: rtl/gpioemu_mac_if.sv
// Address/strobe bus of the GPIO emulator: the master drives address, strobes and
// write data; the slave returns registered read data.
interface gpioemu_mac_if;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_in;
    logic [31:0] sdata_out;

    modport master (
        output saddress,
        output srd,
        output swr,
        output sdata_in,
        input  sdata_out
    );

    modport slave (
        input  saddress,
        input  srd,
        input  swr,
        input  sdata_in,
        output sdata_out
    );
endinterface

// File: rtl/gpioemu_mac.sv
// Bus-mapped shift-add multiplier with bit-serial popcount and op counter.
// Optional GPIOEMU_MAC_OVF_SAT_EN: saturate the published result to all-ones on overflow.
module gpioemu_mac #(
    parameter int unsigned DATA_W    = 24,
    parameter logic [15:0] ADDR_BASE = 16'h0380
) (
    input  logic                clk,
    input  logic                reset,
    gpioemu_mac_if.slave        bus,
    input  logic [31:0]         gpio_in,
    input  logic                gpio_latch,
    output logic [31:0]         gpio_out,
    output logic [31:0]         gpio_in_s_insp
);

    localparam int unsigned AccW = 2 * DATA_W;

    localparam logic [15:0] AddrA1 = ADDR_BASE + 16'h0000;
    localparam logic [15:0] AddrA2 = ADDR_BASE + 16'h0008;
    localparam logic [15:0] AddrW  = ADDR_BASE + 16'h0010;
    localparam logic [15:0] AddrL  = ADDR_BASE + 16'h0018;
    localparam logic [15:0] AddrB  = ADDR_BASE + 16'h0020;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StMult  = 2'd1;
    localparam logic [1:0] StCount = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [1:0] StatNone = 2'b11;
    localparam logic [1:0] StatBusy = 2'b01;
    localparam logic [1:0] StatOk   = 2'b00;
    localparam logic [1:0] StatOvf  = 2'b10;

    localparam logic [5:0] LastMult = 6'(DATA_W - 1);

`ifdef GPIOEMU_MAC_OVF_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    function automatic logic ovf_of(input logic [AccW-1:0] p);
        return |(64'(p) >> 32);
    endfunction

    function automatic logic [31:0] cand_of(input logic [AccW-1:0] p);
        return (SatEn && ovf_of(p)) ? 32'hFFFF_FFFF : 32'(64'(p));
    endfunction

    logic              srd_q, srd_d, swr_q, swr_d;
    logic [DATA_W-1:0] a1_q, a1_d, a2_q, a2_d;
    logic [DATA_W-1:0] a1_w_q, a1_w_d, a2_w_q, a2_w_d;
    logic [AccW-1:0]   acc_q, acc_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [31:0]       shr_q, shr_d;
    logic [5:0]        ones_q, ones_d;
    logic [31:0]       w_q, w_d;
    logic [5:0]        l_q, l_d;
    logic [1:0]        status_q, status_d;
    logic [15:0]       op_count_q, op_count_d;
    logic [1:0]        state_q, state_d;
    logic [31:0]       sdata_out_q, sdata_out_d;
    logic [31:0]       gpio_in_s_q, gpio_in_s_d;

    logic rd_edge, wr_edge, start;

    // Only the low DATA_W bits of the write data reach operand registers.
    logic unused_sdata;
    assign unused_sdata = ^bus.sdata_in;

    always_comb begin
        srd_d       = bus.srd;
        swr_d       = bus.swr;
        rd_edge     = bus.srd & ~srd_q;
        wr_edge     = bus.swr & ~swr_q;
        a1_d        = a1_q;
        a2_d        = a2_q;
        a1_w_d      = a1_w_q;
        a2_w_d      = a2_w_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        shr_d       = shr_q;
        ones_d      = ones_q;
        w_d         = w_q;
        l_d         = l_q;
        status_d    = status_q;
        op_count_d  = op_count_q;
        state_d     = state_q;
        sdata_out_d = sdata_out_q;
        gpio_in_s_d = gpio_latch ? gpio_in : gpio_in_s_q;

        if (wr_edge && bus.saddress == AddrA1) a1_d = bus.sdata_in[DATA_W-1:0];
        if (wr_edge && bus.saddress == AddrA2) a2_d = bus.sdata_in[DATA_W-1:0];
        start = wr_edge && (bus.saddress == AddrB) && bus.sdata_in[0] && (status_q != StatBusy);

        // Read mux sees only current state, so a same-cycle write is not visible yet.
        if (rd_edge) begin
            case (bus.saddress)
                AddrW:   sdata_out_d = w_q;
                AddrL:   sdata_out_d = {26'h0, l_q};
                AddrB:   sdata_out_d = {30'h0, status_q};
                default: sdata_out_d = 32'h0;
            endcase
        end

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StMult;
                    status_d = StatBusy;
                    acc_d    = '0;
                    cnt_d    = '0;
                    a1_w_d   = a1_q;
                    a2_w_d   = a2_q;
                end
            end
            StMult: begin
                if (a2_w_q[0]) acc_d = acc_q + (AccW'(a1_w_q) << cnt_q);
                a2_w_d = a2_w_q >> 1;
                if (cnt_q == LastMult) begin
                    state_d = StCount;
                    cnt_d   = '0;
                    ones_d  = '0;
                    shr_d   = cand_of(acc_d);
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            StCount: begin
                ones_d = ones_q + 6'(shr_q[0]);
                shr_d  = shr_q >> 1;
                if (cnt_q == 6'd31) begin
                    state_d = StDone;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                w_d        = cand_of(acc_q);
                l_d        = ones_q;
                status_d   = ovf_of(acc_q) ? StatOvf : StatOk;
                op_count_d = op_count_q + 16'd1;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            srd_q       <= 1'b0;
            swr_q       <= 1'b0;
            a1_q        <= '0;
            a2_q        <= '0;
            a1_w_q      <= '0;
            a2_w_q      <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            shr_q       <= '0;
            ones_q      <= '0;
            w_q         <= '0;
            l_q         <= '0;
            status_q    <= StatNone;
            op_count_q  <= '0;
            state_q     <= StIdle;
            sdata_out_q <= '0;
            gpio_in_s_q <= '0;
        end else begin
            srd_q       <= srd_d;
            swr_q       <= swr_d;
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a1_w_q      <= a1_w_d;
            a2_w_q      <= a2_w_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            shr_q       <= shr_d;
            ones_q      <= ones_d;
            w_q         <= w_d;
            l_q         <= l_d;
            status_q    <= status_d;
            op_count_q  <= op_count_d;
            state_q     <= state_d;
            sdata_out_q <= sdata_out_d;
            gpio_in_s_q <= gpio_in_s_d;
        end
    end

    assign bus.sdata_out    = sdata_out_q;
    assign gpio_out         = {16'h0, op_count_q};
    assign gpio_in_s_insp   = gpio_in_s_q;

endmodule

// File: tb/tb_gpioemu_mac.sv
// Scoreboard bench for gpioemu_mac: reads push expected data, a monitor checks on read edges.
module tb_gpioemu_mac;

    localparam logic [15:0] Base = 16'h0380;
    localparam logic [15:0] AA1  = Base + 16'h00;
    localparam logic [15:0] AA2  = Base + 16'h08;
    localparam logic [15:0] AW   = Base + 16'h10;
    localparam logic [15:0] AL   = Base + 16'h18;
    localparam logic [15:0] AB   = Base + 16'h20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gpio_in = '0;
    logic        gpio_latch = 1'b0;
    logic [31:0] gpio_out;
    logic [31:0] gpio_in_s_insp;

    gpioemu_mac_if bus();

    gpioemu_mac #(
        .DATA_W   (24),
        .ADDR_BASE(Base)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .gpio_in       (gpio_in),
        .gpio_latch    (gpio_latch),
        .gpio_out      (gpio_out),
        .gpio_in_s_insp(gpio_in_s_insp)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every rising read strobe yields one registered read result.
    initial begin
        logic rd_prev;
        logic fire;
        sb_t  e;
        rd_prev = 1'b0;
        forever begin
            @(posedge clk);
            fire    = bus.srd && !rd_prev && !reset;
            rd_prev = bus.srd;
            if (fire) begin
                #1;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_read: got %h want none", bus.sdata_out);
                end else begin
                    e = sb_q.pop_front();
                    check(e.name, bus.sdata_out, e.exp);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        bus.saddress = a;
        bus.sdata_in = d;
        bus.swr      = 1'b1;
        @(negedge clk);
        bus.swr = 1'b0;
        @(negedge clk);
    endtask

    task automatic bus_rd(input logic [15:0] a, input logic [31:0] exp, input string name);
        sb_q.push_back('{name: name, exp: exp});
        bus.saddress = a;
        bus.srd      = 1'b1;
        @(negedge clk);
        bus.srd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.saddress = '0;
        bus.srd      = 1'b0;
        bus.swr      = 1'b0;
        bus.sdata_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_sdata_out", bus.sdata_out, 32'h0);
        check("rst_gpio_out", gpio_out, 32'h0);
        check("rst_gpio_in_s", gpio_in_s_insp, 32'h0);
        bus_rd(AB, 32'h3, "rst_B");
        bus_rd(AW, 32'h0, "rst_W");
        bus_rd(AL, 32'h0, "rst_L");

        // Basic multiply: START edge t, publish on edge t+57
        bus_wr(AA1, 32'd3);
        bus_wr(AA2, 32'd5);
        bus_wr(AB, 32'h1);
        bus_rd(AB, 32'h1, "busy_B");
        bus_rd(AW, 32'h0, "busy_W_old");
        idle(51);
        bus_rd(AB, 32'h1, "B_on_done_edge");
        bus_rd(AB, 32'h0, "B_after_done");
        bus_rd(AW, 32'h0000000F, "mul_W");
        bus_rd(AL, 32'd4, "mul_L");
        check("mul_gpio_out", gpio_out, 32'd1);

        // Overflow
        bus_wr(AA1, 32'h00FFFFFF);
        bus_wr(AA2, 32'h00FFFFFF);
        bus_wr(AB, 32'h1);
        idle(60);
`ifdef GPIOEMU_MAC_OVF_SAT_EN
        bus_rd(AW, 32'hFFFFFFFF, "ovf_W");
        bus_rd(AL, 32'd32, "ovf_L");
`else
        bus_rd(AW, 32'hFE000001, "ovf_W");
        bus_rd(AL, 32'd8, "ovf_L");
`endif
        bus_rd(AB, 32'h2, "ovf_B");
        check("ovf_gpio_out", gpio_out, 32'd2);

        // START and operand write while busy
        bus_wr(AA1, 32'd3);
        bus_wr(AA2, 32'd5);
        bus_wr(AB, 32'h1);
        bus_wr(AB, 32'h1);
        bus_wr(AA1, 32'd7);
        idle(60);
        bus_rd(AW, 32'd15, "busy_wr_W");
        bus_rd(AL, 32'd4, "busy_wr_L");
        bus_rd(AB, 32'h0, "busy_wr_B");
        check("busy_wr_gpio_out", gpio_out, 32'd3);
        bus_wr(AB, 32'h1);
        idle(60);
        bus_rd(AW, 32'd35, "a1_7_W");
        bus_rd(AL, 32'd3, "a1_7_L");
        check("a1_7_gpio_out", gpio_out, 32'd4);

        // Strobe held high for 5 cycles: one operation only
        bus.saddress = AB;
        bus.sdata_in = 32'h1;
        bus.swr      = 1'b1;
        idle(5);
        bus.swr = 1'b0;
        idle(120);
        check("held_swr_gpio_out", gpio_out, 32'd5);
        bus_rd(16'h03A8, 32'h0, "unmapped");
        bus_rd(AW, 32'd35, "held_swr_W");

        // Reset on cycle 10 of MULT
        bus_wr(AB, 32'h1);
        idle(8);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_sdata_out", bus.sdata_out, 32'h0);
        check("midrst_gpio_out", gpio_out, 32'h0);
        bus_rd(AB, 32'h3, "midrst_B");
        bus_rd(AW, 32'h0, "midrst_W");
        idle(70);
        check("midrst_no_publish", gpio_out, 32'h0);
        bus_rd(AB, 32'h3, "midrst_B_late");

        // Same-cycle read and START write on B: read sees pre-write status
        sb_q.push_back('{name: "rw_same_B", exp: 32'h3});
        bus.saddress = AB;
        bus.sdata_in = 32'h1;
        bus.srd      = 1'b1;
        bus.swr      = 1'b1;
        @(negedge clk);
        bus.srd = 1'b0;
        bus.swr = 1'b0;
        @(negedge clk);
        bus_rd(AB, 32'h1, "rw_same_busy");
        idle(60);
        bus_rd(AB, 32'h0, "zero_op_B");
        bus_rd(AW, 32'h0, "zero_op_W");
        check("zero_op_gpio_out", gpio_out, 32'd1);

        // GPIO latch
        gpio_in    = 32'hA5A5A5A5;
        gpio_latch = 1'b1;
        @(negedge clk);
        gpio_latch = 1'b0;
        gpio_in    = 32'h12345678;
        idle(3);
        check("gpio_latch", gpio_in_s_insp, 32'hA5A5A5A5);

        idle(2);
        check("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gpioemu_mac.md
# gpioemu_mac

Parametrised successor of the GPIO-emulator arithmetic peripheral. It sits on the emulator's simple address/strobe bus, accepts two operands, and runs an iterative shift-add multiplier followed by a bit-serial population count. It publishes the 32-bit result, the ones count and a status code, and exposes a completed-operation counter on `gpio_out`. Unlike the previous block, everything runs in one clock domain, with a configurable operand width and a defined overflow and busy protocol.

## Interface
- `DATA_W`, default 24: operand width. Legal range 8..32.
- `ADDR_BASE`, default 16'h0380: register block base address.
- `clk` in 1: sole clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `saddress` in 16: bus address.
- `srd` in 1: read strobe, level.
- `swr` in 1: write strobe, level.
- `sdata_in` in 32: write data.
- `sdata_out` out 32: registered read data.
- `gpio_in` in 32: external inputs.
- `gpio_latch` in 1: capture enable for `gpio_in`.
- `gpio_out` out 32: `{16'h0, op_count}`.
- `gpio_in_s_insp` out 32: latched `gpio_in`.

## Operation
- **Strobe sampling**
  - `srd` and `swr` are registered each cycle.
  - An access occurs only on a 0→1 transition. Holding a strobe high performs one access.
- **Register map** (offsets from `ADDR_BASE`):
  - +0x00 A1: write. Takes `sdata_in[DATA_W-1:0]`.
  - +0x08 A2: write. Takes `sdata_in[DATA_W-1:0]`.
  - +0x10 W: read. 32-bit result.
  - +0x18 L: read. `{26'h0, ones[5:0]}`.
  - +0x20 B: read returns `{30'h0, status}`. A write with `sdata_in[0]=1` is START.
- **Status codes**
  - 2'b11: no result.
  - 2'b01: busy.
  - 2'b00: done, valid.
  - 2'b10: done, overflow.
- **Operand writes**
  - A1 and A2 accept writes at any time.
  - START copies both into working registers, so later writes do not disturb a running operation.
- **State machine:** IDLE → MULT → COUNT → DONE → IDLE.
  - IDLE: START moves to MULT and clears the accumulator and bit index.
  - MULT: exactly `DATA_W` cycles. Each cycle, if A2 working bit i is 1, add A1 << i into a 2·`DATA_W`-bit accumulator. Unsigned.
  - COUNT: exactly 32 cycles. Shift out the candidate W and add each bit to ones.
  - DONE: one cycle.
    - Publish W and L.
    - Set status to 00, or to 10 when product bits [2·`DATA_W`-1:32] are nonzero. Overflow is impossible for `DATA_W`≤16.
    - `op_count` +1, wrapping from 16'hFFFF to 0.
- **Candidate W:** low 32 bits of the product, or the saturated value (see Configuration). L counts the candidate W.
- **START while status=01:** ignored, with no side effects.
- **Reads**
  - `sdata_out` loads on the read edge.
  - Unmapped address loads 0.
  - Otherwise `sdata_out` holds its last value.
- **GPIO latch:** `gpio_in_s` loads `gpio_in` on every clock with `gpio_latch`=1.

## Timing
- **Reset values**
  - `sdata_out`=0.
  - `gpio_out`=0.
  - `gpio_in_s_insp`=0.
  - W=0, L=0, A1=0, A2=0.
  - status=11.
  - state=IDLE.
- **Reset mid-operation:** aborts. Everything returns to reset values, and an in-flight result is never published.
- **START write on edge t**
  - status=01 after edge t.
  - MULT occupies edges t+1..t+`DATA_W`.
  - COUNT occupies the next 32 edges.
  - DONE is the next edge.
  - W, L, status and `op_count` change together after edge t+`DATA_W`+33. That is 57 cycles for `DATA_W`=24.
- **Read latency:** read edge detected at edge t → `sdata_out` valid after edge t.
- **Read and write edges in the same cycle:** both are performed, and the read returns the pre-write value.
- **Read of W or L while busy:** returns the previous published values.
- **Read of B coinciding with the DONE edge:** returns 01.

## Configuration
- `GPIOEMU_MAC_OVF_SAT_EN`
  - Defined: on overflow the published W = 32'hFFFF_FFFF, so L=32.
  - Undefined: W wraps to the low 32 bits.
- Status 10 is reported in both builds.

## Test plan
- **Basic multiply** (`DATA_W`=24)
  - Stimulus: A1=3, A2=5, START.
  - Response: B reads 01 until the publish edge, 57 cycles after the START edge. Then W=0x0000000F, L=4, B=00, `gpio_out`=1.
- **Overflow**
  - Stimulus: A1=0xFFFFFF, A2=0xFFFFFF.
  - Response without the macro: W=0xFE000001, L=8, B=10.
  - Response with `GPIOEMU_MAC_OVF_SAT_EN`: W=0xFFFFFFFF, L=32, B=10.
- **START and operand writes while busy**
  - Stimulus: START while busy, plus a write A1=7 mid-operation on A1=3, A2=5.
  - Response: result W=15, a single `op_count` increment. The next START uses A1=7 and gives W=35, L=3.
- **Strobe handling**
  - Stimulus: `swr` held high for 5 cycles on START.
  - Response: exactly one operation.
  - Stimulus: read of 0x03A8 (unmapped).
  - Response: `sdata_out`=0.
- **Reset mid-MULT**
  - Stimulus: `reset` high for 1 cycle at cycle 10 of MULT.
  - Response: B=11, W=0, `gpio_out`=0, and no publish follows.
- **GPIO latch**
  - Stimulus: `gpio_in`=0xA5A5A5A5 with `gpio_latch`=1 for one cycle, then `gpio_in` changes with latch low.
  - Response: `gpio_in_s_insp` holds 0xA5A5A5A5.
